// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Purpose  : Elastic pipeline register for inter-stage boundaries. Uses a
//             valid/ready handshake, one register (DEPTH=1) or a 2-entry
//             skid buffer (DEPTH=2), flush squash, and control zeroing on
//             bubbles.
//  Option   : PIPE_PERF_CNT_EN defined   -> saturating stall/bubble counters
//             PIPE_PERF_CNT_EN undefined -> counters tied to zero
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2,   // 1 = single register, 2 = skid buffer
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Encoding doubles as the occupancy value.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_head_data;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [1:0]        w_occ;

  // Flush wins over the handshake: a beat offered on a flush cycle is dropped.
  assign w_push = in_valid & w_ready & ~flush;
  assign w_pop  = w_valid & out_ready;

  generate
    if (DEPTH == 1) begin : g_single
      logic              r_valid;
      logic [DATA_W-1:0] r_data;
      logic [CTRL_W-1:0] r_ctrl;

      // Single entry: a push replaces the entry, even when it is popped in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_data  <= '0;
          r_ctrl  <= '0;
        end else begin
          if (flush)       r_valid <= 1'b0;
          else if (w_push) r_valid <= 1'b1;
          else if (w_pop)  r_valid <= 1'b0;
          if (w_push) begin
            r_data <= in_data;
            r_ctrl <= in_ctrl;
          end
        end
      end

      assign w_valid     = r_valid;
      assign w_ready     = ~r_valid | out_ready;
      assign w_head_data = r_data;
      assign w_head_ctrl = r_ctrl;
      assign w_occ       = {1'b0, r_valid};
    end else begin : g_skid
      // Any DEPTH other than 1 is built as the 2-entry skid buffer; only 2 is legal.
      state_t            r_state;
      state_t            w_state_nxt;
      logic              w_load_head_in;
      logic              w_load_head_skid;
      logic              w_load_skid;
      logic [DATA_W-1:0] r_head_data;
      logic [CTRL_W-1:0] r_head_ctrl;
      logic [DATA_W-1:0] r_skid_data;
      logic [CTRL_W-1:0] r_skid_ctrl;

      // State register.
      always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
      end

      // Next state and steering of the incoming beat into head or skid slot.
      always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
          w_state_nxt = S_EMPTY;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_push) begin
                w_state_nxt    = S_ONE;
                w_load_head_in = 1'b1;
              end
            end
            S_ONE: begin
              if (w_push && w_pop) begin
                w_load_head_in = 1'b1;
              end else if (w_push) begin
                w_state_nxt = S_FULL;
                w_load_skid = 1'b1;
              end else if (w_pop) begin
                w_state_nxt = S_EMPTY;
              end
            end
            S_FULL: begin
              // in_ready is low here, so only a pop can happen.
              if (w_pop) begin
                w_state_nxt      = S_ONE;
                w_load_head_skid = 1'b1;
              end
            end
            default: w_state_nxt = S_EMPTY;
          endcase
        end
      end

      // Payload storage; head holds its value while stalled or empty.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_head_data <= '0;
          r_head_ctrl <= '0;
          r_skid_data <= '0;
          r_skid_ctrl <= '0;
        end else begin
          if (w_load_head_in) begin
            r_head_data <= in_data;
            r_head_ctrl <= in_ctrl;
          end else if (w_load_head_skid) begin
            r_head_data <= r_skid_data;
            r_head_ctrl <= r_skid_ctrl;
          end
          if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end
        end
      end

      assign w_valid     = (r_state != S_EMPTY);
      assign w_ready     = (r_state != S_FULL);   // registered: no path from out_ready
      assign w_head_data = r_head_data;
      assign w_head_ctrl = r_head_ctrl;
      assign w_occ       = r_state;
    end
  endgenerate

  assign in_ready  = w_ready;
  assign out_valid = w_valid;
  assign out_data  = w_head_data;
  assign out_ctrl  = w_valid ? w_head_ctrl : '0;   // bubbles never assert control
  assign occupancy = w_occ;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating stall/bubble counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_valid && !out_ready && (r_stall_cnt != c_CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_valid && (r_bubble_cnt != c_CNT_MAX))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_buf
//  Purpose  : Scoreboard bench for pipe_stage_buf, DEPTH=2 and DEPTH=1
//             instances side by side (CNT_W=4). Counter expectations follow
//             PIPE_PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic        iv2 = 0, or2 = 0, fl2 = 0;
  logic [63:0] id2 = '0;
  logic [15:0] ic2 = '0;
  logic        ir2, ov2;
  logic [63:0] od2;
  logic [15:0] oc2;
  logic [1:0]  occ2;
  logic [3:0]  sc2, bc2;

  // DEPTH=1 instance signals
  logic        iv1 = 0, or1 = 0, fl1 = 0;
  logic [63:0] id1 = '0;
  logic [15:0] ic1 = '0;
  logic        ir1, ov1;
  logic [63:0] od1;
  logic [15:0] oc1;
  logic [1:0]  occ1;
  logic [3:0]  sc1, bc1;

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .DEPTH(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_ctrl(ic2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ctrl(oc2),
    .occupancy(occ2), .stall_cnt(sc2), .bubble_cnt(bc2)
  );

  pipe_stage_buf #(.DATA_W(64), .CTRL_W(16), .DEPTH(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_ctrl(ic1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1),
    .occupancy(occ1), .stall_cnt(sc1), .bubble_cnt(bc1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: one queue of {ctrl,data} per instance (index 0: DEPTH=2, 1: DEPTH=1).
  logic [79:0] sb_q [2][$];
  logic [3:0]  m_stall [2];
  logic [3:0]  m_bubble [2];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk_ctrl(input logic [63:0] d);
    return (d[15:0] ^ 16'hC3A5) | 16'h0001;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
`ifdef PIPE_PERF_CNT_EN
    return (v == 4'hF) ? 4'hF : v + 4'd1;
`else
    return 4'd0;
`endif
  endfunction

  // Reference behaviour for one instance, evaluated mid-cycle with stable inputs.
  task automatic model_step(input int k, input int depth,
                            input logic iv, input logic [63:0] id, input logic [15:0] ic,
                            input logic ordy, input logic fl,
                            input logic ir, input logic ov, input logic [63:0] od,
                            input logic [15:0] oc, input logic [1:0] occ,
                            input logic [3:0] sc, input logic [3:0] bc);
    logic e_valid, e_ready, push, pop;
    string p;
    p = $sformatf("d%0d_", depth);
    if (rst) begin
      sb_q[k].delete();
      m_stall[k]  = '0;
      m_bubble[k] = '0;
    end else begin
      e_valid = (sb_q[k].size() > 0);
      e_ready = (depth == 2) ? (sb_q[k].size() != 2) : (!e_valid || ordy);
      check({p, "in_ready"},  64'(ir),  64'(e_ready));
      check({p, "out_valid"}, 64'(ov),  64'(e_valid));
      check({p, "occupancy"}, 64'(occ), 64'(sb_q[k].size()));
      check({p, "out_ctrl"},  64'(oc),  e_valid ? 64'(sb_q[k][0][79:64]) : 64'd0);
      if (e_valid) check({p, "out_data"}, od, sb_q[k][0][63:0]);
      check({p, "stall_cnt"},  64'(sc), 64'(m_stall[k]));
      check({p, "bubble_cnt"}, 64'(bc), 64'(m_bubble[k]));
      if (e_valid && !ordy) m_stall[k] = sat_inc(m_stall[k]);
      if (!e_valid)         m_bubble[k] = sat_inc(m_bubble[k]);
      push = iv && e_ready && !fl;
      pop  = e_valid && ordy;
      if (fl) begin
        sb_q[k].delete();
      end else begin
        if (pop)  void'(sb_q[k].pop_front());
        if (push) sb_q[k].push_back({ic, id});
      end
    end
  endtask

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    model_step(0, 2, iv2, id2, ic2, or2, fl2, ir2, ov2, od2, oc2, occ2, sc2, bc2);
    model_step(1, 1, iv1, id1, ic1, or1, fl1, ir1, ov1, od1, oc1, occ1, sc1, bc1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input logic v, input logic [63:0] d, input logic r, input logic f);
    iv2 = v; id2 = d; ic2 = mk_ctrl(d); or2 = r; fl2 = f;
  endtask

  task automatic set1(input logic v, input logic [63:0] d, input logic r, input logic f);
    iv1 = v; id1 = d; ic1 = mk_ctrl(d); or1 = r; fl1 = f;
  endtask

  initial begin
    // Reset with an active-looking beat at the inputs.
    rst = 1'b1;
    iv2 = 1; ic2 = 16'hFFFF; id2 = 64'hDEAD;
    iv1 = 1; ic1 = 16'hFFFF; id1 = 64'hBEEF;
    tick(); tick();
    rst = 1'b0;
    set2(0, 0, 0, 0);
    set1(0, 0, 0, 0);

    // Idle long enough for the 4-bit bubble counters to saturate.
    repeat (20) tick();

    // Streaming through the skid buffer.
    for (int i = 0; i < 8; i++) begin
      set2(1, 64'hA0 + 64'(i), 1, 0);
      tick();
    end
    set2(0, 0, 1, 0);
    repeat (3) tick();

    // Backpressure: fill, hold, drain.
    set2(1, 64'h11, 0, 0); tick();
    set2(1, 64'h22, 0, 0); tick();
    set2(0, 0, 0, 0);
    repeat (5) tick();
    set2(0, 0, 1, 0);
    repeat (3) tick();

    // Flush while full, with a beat offered on the flush cycle.
    set2(1, 64'h33, 0, 0); tick();
    set2(1, 64'h44, 0, 0); tick();
    set2(1, 64'h55, 0, 1); tick();
    set2(0, 0, 1, 0);
    repeat (3) tick();

    // Flush with one entry held and in_ready high: offered beat must be dropped.
    set2(1, 64'h66, 0, 0); tick();
    set2(1, 64'h77, 0, 1); tick();
    set2(0, 0, 1, 0);
    repeat (2) tick();

    // Single-register stage: back-to-back push with simultaneous pop.
    set1(1, 64'h10, 1, 0); tick();
    set1(1, 64'h20, 1, 0); tick();
    set1(0, 0, 1, 0);
    repeat (2) tick();

    // Single-register stage under backpressure.
    set1(1, 64'h30, 0, 0); tick();
    set1(1, 64'h40, 0, 0); repeat (3) tick();
    set1(1, 64'h40, 1, 0); tick();
    set1(0, 0, 1, 0);
    repeat (2) tick();

    // Random traffic on both instances, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      set2($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
      set1($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0);
      rst = (i == 200);
      tick();
    end
    rst = 1'b0;
    set2(0, 0, 1, 0);
    set1(0, 0, 1, 0);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
